// File: rtl/lab_link_arbiter.sv
// Round-robin arbiter granting one lab resource to one of five computers, with a per-grant
// hold limit, a one-cycle cooldown between owners and a 7-segment owner display.
module lab_link_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] comps,
  output logic [4:0] grant,
  output logic       busy,
  output logic       timeout,
  output logic [6:0] segs
);

  typedef enum logic [1:0] {StIdle, StGrant, StCooldown} state_e;

  localparam logic [6:0] SegDash = 7'b0000001;

  state_e           state_q;
  logic [2:0]       ptr_q;
  logic [2:0]       owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic [4:0]       grant_q;
  logic             busy_q;
  logic             timeout_q;
  logic [6:0]       segs_q;

  logic       sel_valid;
  logic [2:0] sel_idx;
  logic [3:0] scan_sum;
  logic [2:0] scan_idx;
  logic [2:0] ptr_next;

  function automatic logic [6:0] seg_of(logic [2:0] idx);
    case (idx)
      3'd0:    return 7'b0110000;
      3'd1:    return 7'b1101101;
      3'd2:    return 7'b1111001;
      3'd3:    return 7'b0110011;
      3'd4:    return 7'b1011011;
      default: return SegDash;
    endcase
  endfunction

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 4; k >= 0; k--) begin
      scan_sum = {1'b0, ptr_q} + 4'(k);
      scan_idx = (scan_sum >= 4'd5) ? 3'(scan_sum - 4'd5) : scan_sum[2:0];
      if (comps[scan_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign ptr_next = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      segs_q    <= SegDash;
    end else begin
      case (state_q)
        StIdle: begin
          timeout_q <= 1'b0;
          if (sel_valid) begin
            state_q <= StGrant;
            owner_q <= sel_idx;
            grant_q <= 5'b00001 << sel_idx;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_W'(1);
            segs_q  <= seg_of(sel_idx);
          end
        end
        StGrant: begin
          // Release wins over revoke, so timeout only fires while the owner still requests.
          if (!comps[owner_q] || (cnt_q == CNT_W'(MAX_HOLD))) begin
            state_q   <= StCooldown;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= comps[owner_q];
            segs_q    <= SegDash;
            ptr_q     <= ptr_next;
            cnt_q     <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StCooldown: begin
          state_q   <= StIdle;
          timeout_q <= 1'b0;
        end
        default: begin
          state_q   <= StIdle;
          grant_q   <= '0;
          busy_q    <= 1'b0;
          timeout_q <= 1'b0;
          segs_q    <= SegDash;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
  assign segs    = segs_q;

endmodule

// File: tb/tb_lab_link_arbiter.sv
// Bench for lab_link_arbiter: directed scenarios with literal expectations plus randomized
// requests checked every cycle against a behavioural owner/turn model.
module tb_lab_link_arbiter;

  localparam int MaxHold = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] comps = '0;
  logic [4:0] grant;
  logic       busy;
  logic       timeout;
  logic [6:0] segs;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  lab_link_arbiter #(.MAX_HOLD(MaxHold), .CNT_W(8)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .comps  (comps),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout),
    .segs   (segs)
  );

  always #5 clk = ~clk;

  // Model: who owns the link, how long it has held it, whose turn starts the next scan,
  // and what phase (0 idle, 1 owned, 2 cooldown) the link is in.
  int m_phase = 0;
  int m_owner = -1;
  int m_held  = 0;
  int m_turn  = 0;
  bit m_to    = 1'b0;

  function automatic logic [6:0] digit(int owner);
    logic [6:0] tbl [5];
    tbl = '{7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011};
    if (owner < 0) return 7'b0000001;
    return tbl[owner];
  endfunction

  task automatic check(string name, logic [6:0] act, logic [6:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase = 0; m_owner = -1; m_held = 0; m_turn = 0; m_to = 1'b0;
    end else if (m_phase == 0) begin
      m_to = 1'b0;
      for (int d = 0; d < 5; d++) begin
        if (m_owner < 0 && comps[(m_turn + d) % 5]) m_owner = (m_turn + d) % 5;
      end
      if (m_owner >= 0) begin
        m_phase = 1;
        m_held  = 1;
      end
    end else if (m_phase == 1) begin
      if (!comps[m_owner] || m_held == MaxHold) begin
        m_to    = comps[m_owner];
        m_turn  = (m_owner + 1) % 5;
        m_owner = -1;
        m_phase = 2;
      end else begin
        m_held++;
      end
    end else begin
      m_phase = 0;
      m_to    = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_grant", 7'(grant), (m_owner < 0) ? 7'd0 : 7'(5'b00001 << m_owner));
      check("model_busy", 7'(busy), 7'(m_phase == 1));
      check("model_timeout", 7'(timeout), 7'(m_to));
      check("model_segs", segs, digit(m_owner));
      check("onehot", 7'($countones(grant) <= 1), 7'd1);
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    comps = '0;
    cyc(1);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset held two cycles with everyone requesting.
    rst_n = 1'b0;
    comps = 5'b11111;
    cyc(2);
    cmp_en = 1'b1;
    check("rst_grant", 7'(grant), 7'd0);
    check("rst_busy", 7'(busy), 7'd0);
    check("rst_segs", segs, 7'b0000001);
    rst_n = 1'b1;
    cyc(1);
    check("rst_first_grant", 7'(grant), 7'b0000001);
    check("rst_first_segs", segs, 7'b0110000);

    // Single requester held for three sampled grant cycles.
    do_reset();
    comps = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("single_grant", 7'(grant), 7'b0000100);
    end
    comps = 5'b00000;
    cyc(1);
    check("single_cool_grant", 7'(grant), 7'd0);
    check("single_cool_to", 7'(timeout), 7'd0);
    cyc(2);
    check("single_no_regrant", 7'(grant), 7'd0);

    // Timeout after exactly MaxHold cycles, regrant after one idle cycle.
    do_reset();
    comps = 5'b01000;
    for (int i = 0; i < MaxHold; i++) begin
      cyc(1);
      check("to_hold", 7'(grant), 7'b0001000);
    end
    cyc(1);
    check("to_pulse", 7'(timeout), 7'd1);
    check("to_grant_off", 7'(grant), 7'd0);
    cyc(1);
    check("to_pulse_end", 7'(timeout), 7'd0);
    cyc(1);
    check("to_regrant", 7'(grant), 7'b0001000);

    // Full round robin with wrap, every grant timing out.
    do_reset();
    comps = 5'b11111;
    cyc(1);
    for (int i = 0; i < 6; i++) begin
      check("rr_grant", 7'(grant), 7'(5'b00001 << (i % 5)));
      check("rr_segs", segs, digit(i % 5));
      cyc(MaxHold + 2);
    end

    // Skip and wrap: computer 4 releases, pointer sits at 4, only 1 and 2 request.
    do_reset();
    comps = 5'b01000;
    cyc(1);
    check("wrap_owner4", 7'(grant), 7'b0001000);
    comps = 5'b00011;
    cyc(3);
    check("wrap_grant1", 7'(grant), 7'b0000001);
    cyc(MaxHold + 2);
    check("wrap_grant2", 7'(grant), 7'b0000010);

    // Reset in the middle of a grant.
    do_reset();
    comps = 5'b00010;
    cyc(1);
    check("mid_rst_pre", 7'(grant), 7'b0000010);
    rst_n = 1'b0;
    cyc(1);
    check("mid_rst_grant", 7'(grant), 7'd0);
    check("mid_rst_segs", segs, 7'b0000001);
    rst_n = 1'b1;
    comps = 5'b11111;
    cyc(1);
    check("mid_rst_ptr0", 7'(grant), 7'b0000001);

    // Release on the same cycle the hold limit is reached: no timeout.
    do_reset();
    comps = 5'b00001;
    cyc(MaxHold);
    check("tie_still_held", 7'(grant), 7'b0000001);
    comps = 5'b00000;
    cyc(1);
    check("tie_grant", 7'(grant), 7'd0);
    check("tie_no_timeout", 7'(timeout), 7'd0);

    // Randomized requests with occasional resets, checked by the model each cycle.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) comps = 5'($urandom);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc(1);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
